id_stage_pipe: RTL

Parametrised instruction-decode stage with integrated ID/EX pipeline register for the 5-stage MIPS core. Decodes the IF/ID instruction, reads a write-through register file, resolves BEQ/BNE and J early in ID using forwarded EX/MEM operands, and registers operands and control into EX. Inserts bubbles on load-use data hazards and on flushes.

---
 rtl/cpu_pkg.sv | 33 +++
 rtl/reg_file_wt.sv | 28 ++
 rtl/id_stage_pipe.sv | 105 ++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: opcodes, ALU op classes, decode structs and default widths for the MIPS core.
package cpu_pkg;
  localparam int PC_W_DEF = 10;
  localparam int DATA_W_DEF = 32;
  localparam int REG_AW_DEF = 5;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J = 6'h02;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_BNE = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW = 6'h23;
  localparam logic [5:0] OP_SW = 6'h2B;
  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_FUNCT = 2'b10
  } alu_op_e;
  typedef struct packed {
    alu_op_e alu_op;
    logic mem_to_reg;
    logic mem_read;
    logic mem_write;
    logic alu_src;
    logic reg_write;
  } ex_ctrl_t;
  typedef struct packed {
    ex_ctrl_t ex;
    logic reg_dst;
    logic beq;
    logic bne;
    logic jmp;
  } dec_ctrl_t;
endpackage

// File: rtl/reg_file_wt.sv
// reg_file_wt: write-through register file; r0 is hardwired to zero.
module reg_file_wt #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [REG_AW-1:0] raddr1,
  input  logic [REG_AW-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2
);
  localparam int NUM_REGS = 2 ** REG_AW;
  logic [DATA_W-1:0] regs [NUM_REGS];
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (we && waddr != '0) begin
      regs[waddr] <= wdata;
    end
  end
  // A same-cycle write to the read address is bypassed so ID sees the new value.
  assign rdata1 = (raddr1 == '0) ? '0 : (we && waddr == raddr1) ? wdata : regs[raddr1];
  assign rdata2 = (raddr2 == '0) ? '0 : (we && waddr == raddr2) ? wdata : regs[raddr2];
endmodule

// File: rtl/id_stage_pipe.sv
// id_stage_pipe: MIPS decode stage with early branch/jump resolution and ID/EX register.
module id_stage_pipe
  import cpu_pkg::*;
#(
  parameter int PC_W = PC_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_AW = REG_AW_DEF,
  parameter int BNE_EN = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [PC_W-1:0]   if_id_pc_plus4,
  input  logic [31:0]       if_id_instr,
  input  logic              mem_wb_reg_write,
  input  logic [REG_AW-1:0] mem_wb_write_reg_addr,
  input  logic [DATA_W-1:0] mem_wb_write_back_data,
  input  logic              ex_mem_reg_write,
  input  logic [REG_AW-1:0] ex_mem_dest_reg,
  input  logic [DATA_W-1:0] ex_mem_alu_result,
  input  logic              Data_Hazard,
  input  logic              IF_Flush,
  output logic              branch_taken,
  output logic [PC_W-1:0]   branch_address,
  output logic              jump,
  output logic [PC_W-1:0]   jump_address,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_reg1,
  output logic [DATA_W-1:0] ex_reg2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [REG_AW-1:0] ex_rs,
  output logic [REG_AW-1:0] ex_rt,
  output logic [REG_AW-1:0] ex_dest_reg,
  output logic [1:0]        ex_alu_op,
  output logic              ex_mem_to_reg,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_alu_src,
  output logic              ex_reg_write
);
  logic [5:0] opcode;
  logic [REG_AW-1:0] rs, rt, rd, dest;
  logic [DATA_W-1:0] rd1, rd2, op_a, op_b, imm;
  logic bubble, equal;
  dec_ctrl_t ctrl;
  ex_ctrl_t ex_ctrl;
  assign opcode = if_id_instr[31:26];
  assign rs = if_id_instr[21+:REG_AW];
  assign rt = if_id_instr[16+:REG_AW];
  assign rd = if_id_instr[11+:REG_AW];
  assign imm = {{(DATA_W-16){if_id_instr[15]}}, if_id_instr[15:0]};
  assign dest = ctrl.reg_dst ? rd : rt;
  assign bubble = Data_Hazard | IF_Flush;
  always_comb begin
    ctrl = '0;
    case (opcode)
      OP_RTYPE: begin ctrl.reg_dst = 1'b1; ctrl.ex.reg_write = 1'b1; ctrl.ex.alu_op = ALU_FUNCT; end
      OP_LW: begin ctrl.ex.alu_src = 1'b1; ctrl.ex.mem_read = 1'b1; ctrl.ex.mem_to_reg = 1'b1; ctrl.ex.reg_write = 1'b1; end
      OP_SW: begin ctrl.ex.alu_src = 1'b1; ctrl.ex.mem_write = 1'b1; end
      OP_ADDI: begin ctrl.ex.alu_src = 1'b1; ctrl.ex.reg_write = 1'b1; end
      OP_BEQ: begin ctrl.beq = 1'b1; ctrl.ex.alu_op = ALU_SUB; end
      OP_BNE: if (BNE_EN != 0) begin ctrl.bne = 1'b1; ctrl.ex.alu_op = ALU_SUB; end
      OP_J: ctrl.jmp = 1'b1;
      default: ;
    endcase
  end
  reg_file_wt #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_rf (
    .clk(clk), .reset(reset), .we(mem_wb_reg_write), .waddr(mem_wb_write_reg_addr),
    .wdata(mem_wb_write_back_data), .raddr1(rs), .raddr2(rt), .rdata1(rd1), .rdata2(rd2)
  );
  // Only the comparator sees EX/MEM forwarding; EX gets its own forwarding later.
  assign op_a = (ex_mem_reg_write && ex_mem_dest_reg == rs && rs != '0) ? ex_mem_alu_result : rd1;
  assign op_b = (ex_mem_reg_write && ex_mem_dest_reg == rt && rt != '0) ? ex_mem_alu_result : rd2;
  assign equal = op_a == op_b;
  assign branch_taken = !bubble && ((ctrl.beq && equal) || (ctrl.bne && !equal));
  assign branch_address = if_id_pc_plus4 + PC_W'({imm, 2'b00});
  assign jump = ctrl.jmp && !bubble;
  assign jump_address = PC_W'({if_id_instr[25:0], 2'b00});
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_valid <= 1'b0;
      ex_ctrl <= '0;
      ex_reg1 <= '0;
      ex_reg2 <= '0;
      ex_imm <= '0;
      ex_rs <= '0;
      ex_rt <= '0;
      ex_dest_reg <= '0;
    end else begin
      ex_valid <= !bubble;
      ex_ctrl <= bubble ? '0 : ctrl.ex;
      ex_reg1 <= rd1;
      ex_reg2 <= rd2;
      ex_imm <= imm;
      ex_rs <= rs;
      ex_rt <= rt;
      ex_dest_reg <= dest;
    end
  end
  assign ex_alu_op = ex_ctrl.alu_op;
  assign ex_mem_to_reg = ex_ctrl.mem_to_reg;
  assign ex_mem_read = ex_ctrl.mem_read;
  assign ex_mem_write = ex_ctrl.mem_write;
  assign ex_alu_src = ex_ctrl.alu_src;
  assign ex_reg_write = ex_ctrl.reg_write;
endmodule
